// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the bridge FSM state type.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW_W,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_DONE
    } state_t;

endpackage

// File: rtl/axi_mem_bridge.sv
// CPU memory request to AXI4 master bridge: single reads/writes and aligned INCR line-fill reads,
// one transaction in flight, AXI error responses reported as a sticky flag.
module axi_mem_bridge
    import axi_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int AXI_ID    = 0,
    parameter int BURST_LEN = 4
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic [ADDR_W-1:0]     input_address,
    input  logic [DATA_W-1:0]     input_data,
    input  logic [DATA_W/8-1:0]   input_byteenable,
    input  logic                  input_read,
    input  logic                  input_write,
    input  logic                  input_burst,
    output logic                  output_cache_stall,
    output logic [DATA_W-1:0]     output_read_data,
    output logic                  output_read_valid,
    output logic [3:0]            output_beat,
    output logic                  output_bus_error,

    output logic [ID_W-1:0]       awid,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,

    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,

    input  logic [ID_W-1:0]       bid,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,

    output logic [ID_W-1:0]       arid,
    output logic [ADDR_W-1:0]     araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [ID_W-1:0]       rid,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam int                STRB_W    = DATA_W / 8;
    localparam logic [2:0]        SIZE      = 3'($clog2(STRB_W));
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * STRB_W - 1);

    state_t     state, state_nxt;
    logic       burst_q;
    logic [4:0] beat_cnt;
    logic [4:0] last_idx;

    // Response IDs are accepted regardless of value; only resp[1] matters for errors.
    logic unused_resp;
    assign unused_resp = ^{bid, rid, bresp[0], rresp[0]};

    assign awprot   = 3'b000;
    assign arprot   = 3'b000;
    assign last_idx = burst_q ? 5'(BURST_LEN - 1) : 5'd0;

    assign output_cache_stall = (input_read | input_write) & (state != ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (input_write)     state_nxt = ST_WR_AW_W;
                else if (input_read) state_nxt = ST_RD_AR;
            end
            ST_WR_AW_W: begin
                if ((!awvalid || awready) && (!wvalid || wready)) state_nxt = ST_WR_B;
            end
            ST_WR_B: begin
                if (bvalid) state_nxt = input_read ? ST_RD_AR : ST_DONE;
            end
            ST_RD_AR: begin
                if (arvalid && arready) state_nxt = ST_RD_R;
            end
            ST_RD_R: begin
                if (rvalid && rlast) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state             <= ST_IDLE;
            burst_q           <= 1'b0;
            beat_cnt          <= '0;
            output_read_data  <= '0;
            output_read_valid <= 1'b0;
            output_beat       <= '0;
            output_bus_error  <= 1'b0;
            awid              <= '0;
            awaddr            <= '0;
            awlen             <= '0;
            awsize            <= '0;
            awburst           <= '0;
            awvalid           <= 1'b0;
            wdata             <= '0;
            wstrb             <= '0;
            wlast             <= 1'b0;
            wvalid            <= 1'b0;
            bready            <= 1'b0;
            arid              <= '0;
            araddr            <= '0;
            arlen             <= '0;
            arsize            <= '0;
            arburst           <= '0;
            arvalid           <= 1'b0;
            rready            <= 1'b0;
        end else begin
            state             <= state_nxt;
            output_read_valid <= 1'b0;

            if (state == ST_IDLE && state_nxt != ST_IDLE)
                output_bus_error <= 1'b0;

            // Write address and data are launched together and retire independently.
            if (state == ST_IDLE && input_write) begin
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
                awid    <= ID_W'(AXI_ID);
                awaddr  <= input_address;
                awlen   <= 8'd0;
                awsize  <= SIZE;
                awburst <= BURST_INCR;
                wdata   <= input_data;
                wstrb   <= input_byteenable;
                wlast   <= 1'b1;
            end
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;

            bready <= (state_nxt == ST_WR_B);
            if (bvalid && bready && bresp[1])
                output_bus_error <= 1'b1;

            // Entry into RD_AR comes from IDLE or from the tail of a write.
            if (state_nxt == ST_RD_AR && state != ST_RD_AR) begin
                arvalid  <= 1'b1;
                arid     <= ID_W'(AXI_ID);
                araddr   <= input_burst ? (input_address & ~LINE_MASK) : input_address;
                arlen    <= input_burst ? 8'(BURST_LEN - 1) : 8'd0;
                arsize   <= SIZE;
                arburst  <= BURST_INCR;
                burst_q  <= input_burst;
                beat_cnt <= '0;
            end
            if (arvalid && arready) arvalid <= 1'b0;

            rready <= (state_nxt == ST_RD_R);
            if (rvalid && rready) begin
                output_read_data  <= rdata;
                output_read_valid <= 1'b1;
                output_beat       <= beat_cnt[3:0];
                beat_cnt          <= beat_cnt + 5'd1;
                if (rresp[1] || (rlast && beat_cnt < last_idx))
                    output_bus_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Directed + randomized bench for axi_mem_bridge with a behavioural AXI slave and read-data model.
module tb_axi_mem_bridge;
    import axi_pkg::*;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int ID_W      = 4;
    localparam int BURST_LEN = 4;
    localparam int STRB_W    = DATA_W / 8;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    logic [ADDR_W-1:0] input_address = '0;
    logic [DATA_W-1:0] input_data = '0;
    logic [STRB_W-1:0] input_byteenable = '0;
    logic input_read = 1'b0, input_write = 1'b0, input_burst = 1'b0;
    logic output_cache_stall, output_read_valid, output_bus_error;
    logic [DATA_W-1:0] output_read_data;
    logic [3:0] output_beat;
    logic [ID_W-1:0] awid, arid;
    logic [ID_W-1:0] bid = 4'h5, rid = 4'h5;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst;
    logic awvalid, awready, wvalid, wready, wlast, bready, arvalid, arready, rready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [1:0] bresp, rresp;
    logic bvalid, rvalid, rlast;
    logic [DATA_W-1:0] rdata;

    axi_mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(0), .BURST_LEN(BURST_LEN)) dut (
        .aclk(aclk), .areset(areset),
        .input_address(input_address), .input_data(input_data), .input_byteenable(input_byteenable),
        .input_read(input_read), .input_write(input_write), .input_burst(input_burst),
        .output_cache_stall(output_cache_stall), .output_read_data(output_read_data),
        .output_read_valid(output_read_valid), .output_beat(output_beat), .output_bus_error(output_bus_error),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int n_cmp = 0, n_err = 0, cyc = 0;

    // Slave knobs, changed only between transactions.
    int aw_delay = 0, w_delay = 0, ar_delay = 0, early_n = 0;
    bit r_gaps = 0, r_hold = 0;
    logic [1:0] bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;

    // Slave state and observations.
    int aw_wait, w_wait, ar_wait, r_idx, r_total, r_nidx;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, b_cyc = 0, ar_cyc = 0, proto_err = 0;
    logic aw_got, w_got, aw_pend, w_pend, ar_pend;
    logic [ADDR_W-1:0] r_base, cap_awaddr, cap_araddr, aw_q, ar_q;
    logic [DATA_W-1:0] cap_wdata, w_q;
    logic [STRB_W-1:0] cap_wstrb;
    logic [7:0] cap_awlen, cap_arlen;
    logic [2:0] cap_arsize, cap_awprot;
    logic [1:0] cap_arburst;
    logic [ID_W-1:0] cap_arid;
    logic cap_wlast;

    logic [DATA_W-1:0] got_data[$];
    int got_beat[$];

    function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return (a == 32'h0000_1004) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0000);
    endfunction

    assign awready = awvalid && (aw_wait >= aw_delay);
    assign wready  = wvalid  && (w_wait  >= w_delay);
    assign arready = arvalid && (ar_wait >= ar_delay);
    always_comb r_nidx = r_idx + ((rvalid && rready) ? 1 : 0);

    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (areset) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rlast <= 1'b0; rresp <= 2'b00; rdata <= '0;
            r_idx <= 0; r_total <= 0; r_base <= '0;
            aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;

            // A valid seen without ready must still be up, with the same payload, next edge.
            if (aw_pend && (!awvalid || awaddr != aw_q)) proto_err <= proto_err + 1;
            if (w_pend && (!wvalid || wdata != w_q))     proto_err <= proto_err + 1;
            if (ar_pend && (!arvalid || araddr != ar_q)) proto_err <= proto_err + 1;
            aw_pend <= awvalid && !awready; aw_q <= awaddr;
            w_pend  <= wvalid && !wready;   w_q  <= wdata;
            ar_pend <= arvalid && !arready; ar_q <= araddr;

            if (awvalid && awready) begin
                aw_hs <= aw_hs + 1; aw_got <= 1'b1;
                cap_awaddr <= awaddr; cap_awlen <= awlen; cap_awprot <= awprot;
            end
            if (wvalid && wready) begin
                w_hs <= w_hs + 1; w_got <= 1'b1;
                cap_wdata <= wdata; cap_wstrb <= wstrb; cap_wlast <= wlast;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; b_hs <= b_hs + 1; b_cyc <= cyc;
            end else if (!bvalid && aw_got && w_got) begin
                bvalid <= 1'b1; bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
            end

            if (arvalid && arready) begin
                ar_hs <= ar_hs + 1; ar_cyc <= cyc;
                cap_araddr <= araddr; cap_arlen <= arlen; cap_arsize <= arsize;
                cap_arburst <= arburst; cap_arid <= arid;
                r_base <= araddr; r_idx <= 0;
                r_total <= (early_n > 0) ? early_n : int'(arlen) + 1;
            end else begin
                r_idx <= r_nidx;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (!(arvalid && arready) && !r_hold && r_nidx < r_total && (!rvalid || rready)
                && !(r_gaps && $urandom_range(0, 1) == 1)) begin
                rvalid <= 1'b1;
                rdata  <= mem_fn(r_base + 32'(r_nidx * STRB_W));
                rlast  <= (r_nidx == r_total - 1);
                rresp  <= rresp_cfg;
            end
        end
    end

    always @(negedge aclk)
        if (!areset && output_read_valid) begin
            got_data.push_back(output_read_data);
            got_beat.push_back(int'(output_beat));
        end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input bit rd, input bit wr, input bit bst, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be,
                           output int cycles, output int ar_first, output logic err_at2);
        got_data.delete(); got_beat.delete();
        @(posedge aclk); #1;
        input_read = rd; input_write = wr; input_burst = bst;
        input_address = addr; input_data = data; input_byteenable = be;
        cycles = 0; ar_first = -1; err_at2 = 1'bx;
        do begin
            @(negedge aclk); cycles++;
            if (arvalid && ar_first < 0) ar_first = cycles;
            if (cycles == 2) err_at2 = output_bus_error;
        end while (output_cache_stall && cycles < 300);
        chk("done_in_budget", cycles < 300, 1);
        input_read = 1'b0; input_write = 1'b0; input_burst = 1'b0;
        @(negedge aclk);
    endtask

    task automatic chk_read(input string tag, input logic [31:0] addr, input bit bst, input int nbeats);
        logic [31:0] base;
        base = bst ? (addr & ~32'(BURST_LEN * STRB_W - 1)) : addr;
        chk({tag, "_nbeats"}, got_data.size(), nbeats);
        for (int i = 0; i < got_data.size() && i < nbeats; i++) begin
            chk({tag, "_data"}, got_data[i], mem_fn(base + 32'(i * STRB_W)));
            chk({tag, "_beat"}, got_beat[i], i);
        end
    endtask

    initial begin
        int cycles, ar_first, a0, w0, b0, r0, kind, nb;
        logic e2;
        logic [31:0] addr, data;
        logic [3:0] be;

        // Reset state
        repeat (3) @(negedge aclk);
        chk("reset_valids", {awvalid, wvalid, arvalid, bready, rready, output_read_valid, output_bus_error}, 0);
        chk("reset_addr", {awaddr, araddr}, 0);
        chk("reset_stall", output_cache_stall, 0);
        @(posedge aclk); #1 areset = 1'b0;

        // Single read, zero-wait slave
        a0 = ar_hs;
        run_req(1, 0, 0, 32'h0000_1004, 0, 0, cycles, ar_first, e2);
        chk("t1_latency", cycles, 5);
        chk("t1_arvalid_cycle", ar_first, 2);
        chk("t1_ar", {cap_araddr, cap_arlen, cap_arsize, cap_arburst, cap_arid}, {32'h1004, 8'd0, 3'd2, BURST_INCR, 4'd0});
        chk("t1_ar_count", ar_hs - a0, 1);
        chk_read("t1", 32'h1004, 0, 1);
        chk("t1_err", output_bus_error, 0);

        // Write with delayed awready
        aw_delay = 3; a0 = aw_hs; w0 = w_hs; b0 = b_hs;
        run_req(0, 1, 0, 32'h0000_2000, 32'h1122_3344, 4'b0110, cycles, ar_first, e2);
        chk("t2_aw", {cap_awaddr, cap_awlen, cap_awprot}, {32'h2000, 8'd0, 3'd0});
        chk("t2_w", {cap_wdata, cap_wstrb, cap_wlast}, {32'h1122_3344, 4'b0110, 1'b1});
        chk("t2_hs_counts", {aw_hs - a0, w_hs - w0, b_hs - b0}, {32'd1, 32'd1, 32'd1});
        chk("t2_err", output_bus_error, 0);
        aw_delay = 0;

        // Burst read with rvalid gaps
        r_gaps = 1;
        run_req(1, 0, 1, 32'h0000_103C, 0, 0, cycles, ar_first, e2);
        chk("t3_ar", {cap_araddr, cap_arlen, cap_arburst}, {32'h1030, 8'd3, BURST_INCR});
        chk_read("t3", 32'h103C, 1, 4);
        chk("t3_err", output_bus_error, 0);
        r_gaps = 0;

        // Read and write together: write completes first
        a0 = aw_hs; r0 = ar_hs; b0 = b_hs;
        run_req(1, 1, 0, 32'h0000_3008, 32'hCAFE_F00D, 4'hF, cycles, ar_first, e2);
        chk("t4_counts", {aw_hs - a0, b_hs - b0, ar_hs - r0}, {32'd1, 32'd1, 32'd1});
        chk("t4_order", b_cyc < ar_cyc, 1);
        chk("t4_wdata", cap_wdata, 32'hCAFE_F00D);
        chk_read("t4", 32'h3008, 0, 1);

        // SLVERR write response, sticky until next acceptance
        bresp_cfg = RESP_SLVERR;
        run_req(0, 1, 0, 32'h0000_2010, 32'h5555_AAAA, 4'hF, cycles, ar_first, e2);
        chk("t5_err_set", output_bus_error, 1);
        repeat (3) @(negedge aclk);
        chk("t5_err_sticky", output_bus_error, 1);
        bresp_cfg = RESP_OKAY;
        run_req(1, 0, 0, 32'h0000_1008, 0, 0, cycles, ar_first, e2);
        chk("t5_err_cleared_on_accept", e2, 0);
        chk("t5_err_after_ok", output_bus_error, 0);

        // Early rlast on a burst
        early_n = 2;
        run_req(1, 0, 1, 32'h0000_5014, 0, 0, cycles, ar_first, e2);
        chk_read("early", 32'h5014, 1, 2);
        chk("early_err", output_bus_error, 1);
        early_n = 0;

        // Randomized mix against the address/data model
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 2);
            addr = 32'h0000_8000 + ($urandom & 32'h0000_0FFC);
            data = $urandom;
            be = 4'($urandom_range(1, 15));
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3); r_gaps = 1'($urandom_range(0, 1));
            bresp_cfg = ($urandom_range(0, 4) == 0) ? RESP_DECERR : RESP_OKAY;
            rresp_cfg = ($urandom_range(0, 4) == 0) ? RESP_SLVERR : RESP_OKAY;
            a0 = aw_hs; r0 = ar_hs;
            run_req(kind != 1, kind == 1, kind == 2, addr, data, be, cycles, ar_first, e2);
            if (kind == 1) begin
                chk("rnd_aw_count", aw_hs - a0, 1);
                chk("rnd_w", {cap_awaddr, cap_wdata, cap_wstrb}, {addr, data, be});
                chk("rnd_werr", output_bus_error, bresp_cfg[1]);
            end else begin
                nb = (kind == 2) ? BURST_LEN : 1;
                chk("rnd_ar_count", ar_hs - r0, 1);
                chk("rnd_ar", {cap_araddr, cap_arlen},
                    {(kind == 2) ? (addr & ~32'(BURST_LEN * STRB_W - 1)) : addr, 8'(nb - 1)});
                chk_read("rnd", addr, kind == 2, nb);
                chk("rnd_rerr", output_bus_error, rresp_cfg[1]);
            end
        end
        aw_delay = 0; w_delay = 0; ar_delay = 0; r_gaps = 0;
        bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY;

        // Reset in the middle of the read data phase
        r_hold = 1;
        @(posedge aclk); #1;
        input_read = 1'b1; input_burst = 1'b0; input_address = 32'h0000_4000;
        for (int i = 0; i < 50 && !rready; i++) @(negedge aclk);
        chk("t6_in_rd_r", rready, 1);
        @(posedge aclk); #1 areset = 1'b1;
        @(posedge aclk); @(negedge aclk);
        chk("t6_valids_cleared", {awvalid, wvalid, arvalid, bready, rready, output_read_valid}, 0);
        chk("t6_stall_follows_read", output_cache_stall, 1);
        input_read = 1'b0; #1;
        chk("t6_stall_idle", output_cache_stall, 0);
        @(posedge aclk); #1 areset = 1'b0; r_hold = 0;

        // Post-reset sanity read
        run_req(1, 0, 0, 32'h0000_1004, 0, 0, cycles, ar_first, e2);
        chk("t6_after_latency", cycles, 5);
        chk_read("t6_after", 32'h1004, 0, 1);

        chk("handshake_rules", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
